// File: rtl/cms_ctrl_axil_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cms_ctrl_axil_bridge
//
// AXI4-Lite slave that initiates transfers on the continuous monitoring
// system's ctrl port. Each host write becomes a one-cycle ctrl_write_enable
// strobe. Each host read becomes a one-cycle ctrl_read_enable strobe, and the
// returned ctrl_rdata is captured for the R channel. Only one transaction is
// in flight at a time.
//
// Optional build macro: CMS_CTRL_PARTIAL_WRITE_EN
//   defined   : a write with s_wstrb other than all-ones performs a
//               read-modify-write (RMW_READ, RMW_MERGE). wstrb == 0 completes
//               OKAY with no strobes.
//   undefined : a partial-strobe write completes with SLVERR and no strobes.
//
// Ports
//   CLK, RST_N           clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*      AXI-Lite write address / data / response channels
//   s_ar*/s_r*           AXI-Lite read address / data channels
//   ctrl_addr            ctrl register index (addr[10:3])
//   ctrl_wdata           ctrl write data
//   ctrl_write_enable    one-cycle write strobe
//   ctrl_read_enable     one-cycle read strobe
//   ctrl_rdata           ctrl read data, valid exactly one cycle after the strobe
//   dbg_state            current FSM state encoding
//
// Handshake: every AXI channel transfers on a rising CLK edge where both
// valid and ready are high. The readies are combinational from registered
// state (and, for arready, the current AW/W valids); the responses (bvalid,
// rvalid) are registered and stay high, with stable payload, until the
// matching ready is seen.
// -----------------------------------------------------------------------------
module cms_ctrl_axil_bridge #(
  parameter int AXIL_ADDR_WIDTH = 12,
  parameter int CTRL_ADDR_WIDTH = 8,
  parameter int CTRL_DATA_WIDTH = 64,
  parameter int NUM_CTRL_REGS   = 11
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [AXIL_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [CTRL_DATA_WIDTH-1:0]   s_wdata,
  input  logic [CTRL_DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]   s_araddr,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [CTRL_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [CTRL_ADDR_WIDTH-1:0]   ctrl_addr,
  output logic [CTRL_DATA_WIDTH-1:0]   ctrl_wdata,
  output logic                         ctrl_write_enable,
  output logic                         ctrl_read_enable,
  input  logic [CTRL_DATA_WIDTH-1:0]   ctrl_rdata,
  output logic [2:0]                   dbg_state
);

  localparam int STRB_WIDTH = CTRL_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [CTRL_ADDR_WIDTH-1:0] NUM_REGS_W = CTRL_ADDR_WIDTH'(NUM_CTRL_REGS);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_ISSUE   = 3'd1,
    ST_WR_RESP    = 3'd2,
    ST_RD_ISSUE   = 3'd3,
    ST_RD_CAPTURE = 3'd4,
    ST_RD_RESP    = 3'd5
`ifdef CMS_CTRL_PARTIAL_WRITE_EN
    ,
    ST_RMW_READ   = 3'd6,
    ST_RMW_MERGE  = 3'd7
`endif
  } state_t;

  state_t                       state;
  logic [1:0]                   init_q;     // delays readies to the 2nd edge after reset release
  logic                         aw_full;
  logic                         w_full;
  logic [AXIL_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [CTRL_DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_WIDTH-1:0]        w_strb_q;
  logic                         rd_prio;    // 1: a read wins the next write/read collision
  logic                         err_q;      // current transaction gets SLVERR

  // Address decode: 8-byte aligned, upper bits clear, index in range.
  function automatic logic addr_err(input logic [AXIL_ADDR_WIDTH-1:0] addr);
    return (addr[2:0] != 3'b000) ||
           (addr[AXIL_ADDR_WIDTH-1:11] != '0) ||
           (addr[3 +: CTRL_ADDR_WIDTH] >= NUM_REGS_W);
  endfunction

`ifdef CMS_CTRL_PARTIAL_WRITE_EN
  function automatic logic [CTRL_DATA_WIDTH-1:0] merge_bytes(
    input logic [CTRL_DATA_WIDTH-1:0] old_d,
    input logic [CTRL_DATA_WIDTH-1:0] new_d,
    input logic [STRB_WIDTH-1:0]      strb
  );
    logic [CTRL_DATA_WIDTH-1:0] m;
    m = old_d;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (strb[i]) m[8*i +: 8] = new_d[8*i +: 8];
    end
    return m;
  endfunction
`endif

  logic                       idle;
  logic                       ready_en;
  logic                       aw_hs;
  logic                       w_hs;
  logic                       ar_hs;
  logic                       wr_complete;
  logic [AXIL_ADDR_WIDTH-1:0] wr_addr;
  logic [CTRL_DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0]      wr_strb;
  logic                       wr_addr_err;
  logic                       rd_addr_err;

  assign idle     = (state == ST_IDLE);
  assign ready_en = init_q[1];

  assign s_awready = idle && ready_en && !aw_full;
  assign s_wready  = idle && ready_en && !w_full;
  // A read is only offered when no write is half-collected. When AW and W
  // arrive together with AR, arready doubles as the arbitration grant.
  assign s_arready = idle && ready_en && !aw_full && !w_full &&
                     !(s_awvalid && s_wvalid && !rd_prio);

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid  && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // Write payload as seen at the grant edge: latched copy, or the beat
  // arriving in this very cycle.
  assign wr_addr     = aw_full ? aw_addr_q : s_awaddr;
  assign wr_data     = w_full  ? w_data_q  : s_wdata;
  assign wr_strb     = w_full  ? w_strb_q  : s_wstrb;
  assign wr_complete = (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_addr_err = addr_err(wr_addr);
  assign rd_addr_err = addr_err(s_araddr);

  assign dbg_state = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state             <= ST_IDLE;
      init_q            <= 2'b00;
      aw_full           <= 1'b0;
      w_full            <= 1'b0;
      aw_addr_q         <= '0;
      w_data_q          <= '0;
      w_strb_q          <= '0;
      rd_prio           <= 1'b0;
      err_q             <= 1'b0;
      s_bresp           <= RESP_OKAY;
      s_bvalid          <= 1'b0;
      s_rdata           <= '0;
      s_rresp           <= RESP_OKAY;
      s_rvalid          <= 1'b0;
      ctrl_addr         <= '0;
      ctrl_wdata        <= '0;
      ctrl_write_enable <= 1'b0;
      ctrl_read_enable  <= 1'b0;
    end else begin
      init_q            <= {init_q[0], 1'b1};
      ctrl_write_enable <= 1'b0;
      ctrl_read_enable  <= 1'b0;

      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s_awaddr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end

      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            rd_prio <= 1'b0;
            err_q   <= rd_addr_err;
            state   <= ST_RD_ISSUE;
            if (!rd_addr_err) begin
              ctrl_read_enable <= 1'b1;
              ctrl_addr        <= s_araddr[3 +: CTRL_ADDR_WIDTH];
            end
          end else if (wr_complete) begin
            rd_prio <= 1'b1;
            if (wr_addr_err) begin
              err_q <= 1'b1;
              state <= ST_WR_ISSUE;
            end else if (wr_strb == '1) begin
              err_q             <= 1'b0;
              ctrl_write_enable <= 1'b1;
              ctrl_addr         <= wr_addr[3 +: CTRL_ADDR_WIDTH];
              ctrl_wdata        <= wr_data;
              state             <= ST_WR_ISSUE;
            end
`ifdef CMS_CTRL_PARTIAL_WRITE_EN
            else if (wr_strb == '0) begin
              // Nothing to change: answer OKAY without touching the core.
              err_q <= 1'b0;
              state <= ST_WR_ISSUE;
            end else begin
              err_q            <= 1'b0;
              ctrl_read_enable <= 1'b1;
              ctrl_addr        <= wr_addr[3 +: CTRL_ADDR_WIDTH];
              state            <= ST_RMW_READ;
            end
`else
            else begin
              err_q <= 1'b1;
              state <= ST_WR_ISSUE;
            end
`endif
          end
        end

        ST_WR_ISSUE: begin
          s_bvalid <= 1'b1;
          s_bresp  <= err_q ? RESP_SLVERR : RESP_OKAY;
          state    <= ST_WR_RESP;
        end

        ST_WR_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        ST_RD_ISSUE: begin
          state <= ST_RD_CAPTURE;
        end

        ST_RD_CAPTURE: begin
          // ctrl_rdata is valid in this cycle, one after the strobe.
          s_rdata  <= err_q ? '0 : ctrl_rdata;
          s_rresp  <= err_q ? RESP_SLVERR : RESP_OKAY;
          s_rvalid <= 1'b1;
          state    <= ST_RD_RESP;
        end

        ST_RD_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= ST_IDLE;
          end
        end

`ifdef CMS_CTRL_PARTIAL_WRITE_EN
        ST_RMW_READ: begin
          state <= ST_RMW_MERGE;
        end

        ST_RMW_MERGE: begin
          // ctrl_addr still holds the index set by the RMW read strobe.
          ctrl_wdata        <= merge_bytes(ctrl_rdata, w_data_q, w_strb_q);
          ctrl_write_enable <= 1'b1;
          state             <= ST_WR_ISSUE;
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cms_ctrl_axil_bridge.sv
`timescale 1ns/1ps
// Directed testbench for cms_ctrl_axil_bridge. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_cms_ctrl_axil_bridge;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic [11:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [11:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [7:0]  ctrl_addr;
  logic [63:0] ctrl_wdata;
  logic        ctrl_write_enable;
  logic        ctrl_read_enable;
  logic [63:0] ctrl_rdata = JUNK;
  logic [2:0]  dbg_state;

  cms_ctrl_axil_bridge dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .s_awaddr          (s_awaddr),
    .s_awvalid         (s_awvalid),
    .s_awready         (s_awready),
    .s_wdata           (s_wdata),
    .s_wstrb           (s_wstrb),
    .s_wvalid          (s_wvalid),
    .s_wready          (s_wready),
    .s_bresp           (s_bresp),
    .s_bvalid          (s_bvalid),
    .s_bready          (s_bready),
    .s_araddr          (s_araddr),
    .s_arvalid         (s_arvalid),
    .s_arready         (s_arready),
    .s_rdata           (s_rdata),
    .s_rresp           (s_rresp),
    .s_rvalid          (s_rvalid),
    .s_rready          (s_rready),
    .ctrl_addr         (ctrl_addr),
    .ctrl_wdata        (ctrl_wdata),
    .ctrl_write_enable (ctrl_write_enable),
    .ctrl_read_enable  (ctrl_read_enable),
    .ctrl_rdata        (ctrl_rdata),
    .dbg_state         (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [71:0] exp_q[$];          // expected {ctrl_addr, ctrl_wdata} per write strobe
  logic        overlap_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [71:0] exp_w;
    if (ctrl_write_enable && ctrl_read_enable) overlap_seen = 1'b1;
    if (ctrl_write_enable) begin
      exp_w = {8'hFF, JUNK};      // no strobe expected: impossible index
      if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      check_eq("wr_strobe_payload", {ctrl_addr, ctrl_wdata}, exp_w);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic start_write(input logic [11:0] a, input logic [63:0] d, input logic [7:0] s);
    @(negedge CLK);
    s_awaddr = a; s_awvalid = 1'b1;
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    #1;
    check_eq("awready", s_awready, 1);
    check_eq("wready", s_wready, 1);
  endtask

  // Called in the slot whose rising edge completes the write handshake.
  task automatic wr_tail(input logic exp_we, input logic [7:0] exp_addr,
                         input logic [63:0] exp_wdata, input logic [1:0] exp_resp);
    if (exp_we) exp_q.push_back({exp_addr, exp_wdata});
    @(negedge CLK);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    check_eq("wr_strobe", ctrl_write_enable, exp_we);
    check_eq("wr_no_rd_strobe", ctrl_read_enable, 0);
    @(negedge CLK); #1;
    check_eq("bvalid", s_bvalid, 1);
    check_eq("bresp", s_bresp, exp_resp);
    check_eq("wr_strobe_1cyc", ctrl_write_enable, 0);
    s_bready = 1'b1;
    @(negedge CLK);
    s_bready = 1'b0;
    #1;
    check_eq("bvalid_clr", s_bvalid, 0);
  endtask

  task automatic start_read(input logic [11:0] a);
    @(negedge CLK);
    s_araddr = a; s_arvalid = 1'b1;
    #1;
    check_eq("arready", s_arready, 1);
  endtask

  // Called in the slot whose rising edge completes the AR handshake.
  task automatic rd_tail(input logic exp_re, input logic [7:0] exp_addr, input logic [63:0] cms_val,
                         input logic [63:0] exp_data, input logic [1:0] exp_resp, input int hold);
    @(negedge CLK);
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    check_eq("rd_strobe", ctrl_read_enable, exp_re);
    if (exp_re) check_eq("rd_addr", ctrl_addr, exp_addr);
    check_eq("rd_no_wr_strobe", ctrl_write_enable, 0);
    @(negedge CLK);
    ctrl_rdata = cms_val;
    #1;
    check_eq("rvalid_early", s_rvalid, 0);
    check_eq("rd_strobe_1cyc", ctrl_read_enable, 0);
    @(negedge CLK);
    ctrl_rdata = JUNK;
    #1;
    check_eq("rvalid", s_rvalid, 1);
    check_eq("rdata", s_rdata, exp_data);
    check_eq("rresp", s_rresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK); #1;
      check_eq("rvalid_held", s_rvalid, 1);
      check_eq("rdata_stable", s_rdata, exp_data);
    end
    s_rready = 1'b1;
    @(negedge CLK);
    s_rready = 1'b0;
    #1;
    check_eq("rvalid_clr", s_rvalid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_awready"}, s_awready, 0);
    check_eq({tag, "_wready"}, s_wready, 0);
    check_eq({tag, "_arready"}, s_arready, 0);
    check_eq({tag, "_bvalid"}, s_bvalid, 0);
    check_eq({tag, "_rvalid"}, s_rvalid, 0);
    check_eq({tag, "_strobes"}, {ctrl_write_enable, ctrl_read_enable}, 0);
    check_eq({tag, "_ctrl_addr"}, ctrl_addr, 0);
    check_eq({tag, "_ctrl_wdata"}, ctrl_wdata, 0);
    check_eq({tag, "_rdata"}, s_rdata, 0);
    check_eq({tag, "_resps"}, {s_bresp, s_rresp}, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check_eq("ready_at_release", s_awready, 0);
    @(negedge CLK); #1;
    check_eq("ready_after_edge1", {s_awready, s_wready, s_arready}, 3'b000);
    @(negedge CLK); #1;
    check_eq("ready_after_edge2", {s_awready, s_wready, s_arready}, 3'b111);

    // Basic write: index 2.
    start_write(12'h010, 64'h0000_0000_8000_1000, 8'hFF);
    wr_tail(1'b1, 8'd2, 64'h0000_0000_8000_1000, 2'b00);

    // Basic read: index 9, response held back 5 cycles.
    start_read(12'h048);
    rd_tail(1'b1, 8'd9, 64'h1234, 64'h1234, 2'b00, 5);

    // Decode errors.
    start_write(12'h058, 64'h5A5A, 8'hFF);
    wr_tail(1'b0, 8'd0, 64'd0, 2'b10);
    check_eq("ctrl_addr_hold", ctrl_addr, 8'd9);
    start_read(12'h004);
    rd_tail(1'b0, 8'd0, 64'hFFFF, 64'd0, 2'b10, 0);
    start_read(12'h800);
    rd_tail(1'b0, 8'd0, 64'hFFFF, 64'd0, 2'b10, 0);

    // W three cycles before AW; AR raised once W is latched.
    @(negedge CLK);
    s_wdata = 64'h55; s_wstrb = 8'hFF; s_wvalid = 1'b1;
    #1;
    check_eq("w_early_wready", s_wready, 1);
    @(negedge CLK);
    s_wvalid = 1'b0; s_araddr = 12'h008; s_arvalid = 1'b1;
    #1;
    check_eq("ar_blocked_w_latched", s_arready, 0);
    @(negedge CLK); #1;
    check_eq("ar_blocked_w_latched2", s_arready, 0);
    @(negedge CLK);
    s_awaddr = 12'h018; s_awvalid = 1'b1;
    #1;
    check_eq("aw_late_awready", s_awready, 1);
    check_eq("ar_blocked_aw_arrives", s_arready, 0);
    wr_tail(1'b1, 8'd3, 64'h55, 2'b00);
    check_eq("ar_granted_after_wr", s_arready, 1);
    rd_tail(1'b1, 8'd1, 64'h77, 64'h77, 2'b00, 0);

    // Collision after a read: write wins, then read.
    @(negedge CLK);
    s_awaddr = 12'h020; s_awvalid = 1'b1;
    s_wdata = 64'h99; s_wstrb = 8'hFF; s_wvalid = 1'b1;
    s_araddr = 12'h028; s_arvalid = 1'b1;
    #1;
    check_eq("collide_ar_loses", s_arready, 0);
    check_eq("collide_aw_taken", s_awready, 1);
    wr_tail(1'b1, 8'd4, 64'h99, 2'b00);
    check_eq("collide_ar_next", s_arready, 1);
    rd_tail(1'b1, 8'd5, 64'h5555, 64'h5555, 2'b00, 0);

    // Collision after a write: read wins, latched write follows.
    start_write(12'h030, 64'h66, 8'hFF);
    wr_tail(1'b1, 8'd6, 64'h66, 2'b00);
    @(negedge CLK);
    s_awaddr = 12'h038; s_awvalid = 1'b1;
    s_wdata = 64'hCC; s_wstrb = 8'hFF; s_wvalid = 1'b1;
    s_araddr = 12'h040; s_arvalid = 1'b1;
    #1;
    check_eq("collide2_ar_wins", s_arready, 1);
    check_eq("collide2_aw_latched", {s_awready, s_wready}, 2'b11);
    rd_tail(1'b1, 8'd8, 64'h8888, 64'h8888, 2'b00, 0);
    wr_tail(1'b1, 8'd7, 64'hCC, 2'b00);

    // Partial write strobes.
`ifdef CMS_CTRL_PARTIAL_WRITE_EN
    start_write(12'h000, 64'h1111_1111_2222_2222, 8'h0F);
    exp_q.push_back({8'd0, 64'hAAAA_AAAA_2222_2222});
    @(negedge CLK);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    check_eq("rmw_rd_strobe", {ctrl_read_enable, ctrl_write_enable}, 2'b10);
    check_eq("rmw_rd_addr", ctrl_addr, 8'd0);
    @(negedge CLK);
    ctrl_rdata = 64'hAAAA_AAAA_BBBB_BBBB;
    #1;
    check_eq("rmw_merge_quiet", {ctrl_read_enable, ctrl_write_enable}, 2'b00);
    @(negedge CLK);
    ctrl_rdata = JUNK;
    #1;
    check_eq("rmw_wr_strobe", {ctrl_read_enable, ctrl_write_enable}, 2'b01);
    check_eq("rmw_bvalid_early", s_bvalid, 0);
    @(negedge CLK); #1;
    check_eq("rmw_bvalid", s_bvalid, 1);
    check_eq("rmw_bresp", s_bresp, 2'b00);
    s_bready = 1'b1;
    @(negedge CLK);
    s_bready = 1'b0;
    #1;
    check_eq("rmw_bvalid_clr", s_bvalid, 0);
    start_write(12'h008, 64'h1234, 8'h00);
    wr_tail(1'b0, 8'd0, 64'd0, 2'b00);
`else
    start_write(12'h000, 64'h1111_1111_2222_2222, 8'h0F);
    wr_tail(1'b0, 8'd0, 64'd0, 2'b10);
    start_write(12'h008, 64'h1234, 8'h00);
    wr_tail(1'b0, 8'd0, 64'd0, 2'b10);
`endif

    // Reset pulse during RD_CAPTURE (index 10, last valid).
    start_read(12'h050);
    @(negedge CLK);
    s_arvalid = 1'b0;
    #1;
    check_eq("rst_rd_strobe", ctrl_read_enable, 1);
    check_eq("rst_rd_addr", ctrl_addr, 8'd10);
    @(negedge CLK);
    ctrl_rdata = 64'h4444;
    RST_N = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check_eq("rst2_release_ready", s_arready, 0);
    @(negedge CLK);
    ctrl_rdata = JUNK;
    #1;
    check_eq("rst2_edge1_ready", {s_awready, s_wready, s_arready}, 3'b000);
    check_eq("rst2_edge1_rvalid", s_rvalid, 0);
    @(negedge CLK); #1;
    check_eq("rst2_edge2_ready", {s_awready, s_wready, s_arready}, 3'b111);
    check_eq("rst2_no_rvalid", s_rvalid, 0);

    // Write to the last valid index after recovery.
    start_write(12'h050, 64'h0ABC, 8'hFF);
    wr_tail(1'b1, 8'd10, 64'h0ABC, 2'b00);

    repeat (2) @(negedge CLK);
    check_eq("wr_queue_drained", exp_q.size(), 0);
    check_eq("strobe_overlap", overlap_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
